// File: rtl/mio_bus_pkg.sv
// Shared types and constants for the registered CPU memory/IO bus controller.
// Holds the FSM state encoding, the region constants and the address decode helper.
// Setting MIO_BUS_ERRLOG_EN at build time enables error logging in the top; this package is unaffected.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAM  = 2'd1,
    ST_PER  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_PER  = 2'd2
  } tgt_e;

  typedef struct packed {
    tgt_e       tgt;
    logic [3:0] idx;
  } dec_t;

  localparam logic [3:0]  RAM_REGION = 4'h0;
  localparam logic [3:0]  IO_REGION  = 4'hF;
  localparam logic [31:0] ERR_RDATA  = 32'h0;

  // Map a byte address to RAM, one of num_periph peripherals, or nothing.
  function automatic dec_t mio_decode(input logic [31:0] addr, input int num_periph);
    dec_t d;
    d.tgt = TGT_NONE;
    d.idx = addr[27:24];
    if (addr[31:28] == RAM_REGION) begin
      d.tgt = TGT_RAM;
    end else if (addr[31:28] == IO_REGION && int'(addr[27:24]) < num_periph) begin
      d.tgt = TGT_PER;
    end
    return d;
  endfunction

endpackage

// File: rtl/mio_timeout_cnt.sv
// Peripheral wait watchdog: counts enabled cycles, flags expiry on the TIMEOUT-th one.
// Latency: expired is combinational from the count, asserted during the TIMEOUT-th enabled cycle.
// Backpressure: none; the counter saturates at TIMEOUT and never wraps.
module mio_timeout_cnt
  import mio_bus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count enabled cycles up to the saturation point.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/mio_bus_ctrl.sv
// Registered CPU bus controller: decodes to RAM / NUM_PERIPH peripherals / unmapped, one-cycle ready pulse.
// Latency: RAM RAM_LAT+1, unmapped 1, peripheral wait+1 (watchdog error after TIMEOUT waits); one IDLE cycle between accesses.
// Backpressure: cpu_req held until cpu_ready; MIO_BUS_ERRLOG_EN enables err_addr/err_cnt logging.
module mio_bus_ctrl #(
  parameter int NUM_PERIPH = 4,
  parameter int DW         = 32,
  parameter int RAM_AW     = 10,
  parameter int RAM_LAT    = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_err,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic [DW-1:0]            ram_din,
  output logic                     ram_we,
  input  logic [DW-1:0]            ram_dout,
  output logic [NUM_PERIPH-1:0]    per_sel,
  output logic                     per_we,
  output logic [7:0]               per_addr,
  output logic [DW-1:0]            per_wdata,
  input  logic [NUM_PERIPH*DW-1:0] per_rdata,
  input  logic [NUM_PERIPH-1:0]    per_ready,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_cnt
);
  import mio_bus_pkg::*;

  localparam int LCW = $clog2(RAM_LAT + 1);

  state_e                  state_q;
  logic [31:0]             addr_q;
  logic                    we_q;
  logic [LCW-1:0]          lat_q;
  logic [DW-1:0]           rdata_q;
  logic                    ready_q;
  logic                    err_q;
  logic                    ram_we_q;
  logic [RAM_AW-1:0]       ram_addr_q;
  logic [DW-1:0]           ram_din_q;
  logic [NUM_PERIPH-1:0]   per_sel_q;
  logic                    per_we_q;
  logic [7:0]              per_addr_q;
  logic [DW-1:0]           per_wdata_q;

  dec_t                    dec;
  logic                    sel_rdy;
  logic [DW-1:0]           sel_rdata;
  logic                    tmo_clr;
  logic                    tmo_en;
  logic                    tmo_expired;

  assign dec     = mio_decode(cpu_addr, NUM_PERIPH);
  assign sel_rdy = |(per_ready & per_sel_q);
  assign tmo_clr = (state_q == ST_IDLE);
  assign tmo_en  = (state_q == ST_PER);

  // Read data of the selected channel; per_sel_q is one-hot so an OR-mux suffices.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (per_sel_q[i]) sel_rdata = sel_rdata | per_rdata[i*DW +: DW];
    end
  end

  mio_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Access FSM with registered bus strobes and CPU response; reset aborts any access silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      lat_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      per_sel_q   <= '0;
      per_we_q    <= 1'b0;
      per_addr_q  <= '0;
      per_wdata_q <= '0;
    end else begin
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      ram_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            addr_q      <= cpu_addr;
            we_q        <= cpu_we;
            ram_addr_q  <= cpu_addr[RAM_AW+1:2];
            ram_din_q   <= cpu_wdata;
            per_addr_q  <= cpu_addr[7:0];
            per_wdata_q <= cpu_wdata;
            case (dec.tgt)
              TGT_RAM: begin
                state_q  <= ST_RAM;
                lat_q    <= LCW'(RAM_LAT);
                ram_we_q <= cpu_we;
              end
              TGT_PER: begin
                state_q   <= ST_PER;
                per_sel_q <= NUM_PERIPH'(1) << dec.idx;
                per_we_q  <= cpu_we;
              end
              default: begin
                state_q <= ST_RESP;
                ready_q <= 1'b1;
                err_q   <= 1'b1;
                if (!cpu_we) rdata_q <= DW'(ERR_RDATA);
              end
            endcase
          end
        end
        ST_RAM: begin
          if (lat_q == LCW'(1)) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            if (!we_q) rdata_q <= ram_dout;
          end else begin
            lat_q <= lat_q - LCW'(1);
          end
        end
        ST_PER: begin
          if (sel_rdy) begin
            state_q   <= ST_RESP;
            ready_q   <= 1'b1;
            per_sel_q <= '0;
            per_we_q  <= 1'b0;
            if (!we_q) rdata_q <= sel_rdata;
          end else if (tmo_expired) begin
            state_q   <= ST_RESP;
            ready_q   <= 1'b1;
            err_q     <= 1'b1;
            per_sel_q <= '0;
            per_we_q  <= 1'b0;
            if (!we_q) rdata_q <= DW'(ERR_RDATA);
          end
        end
        default: begin
          // RESP: the ready pulse drops here; cpu_req is not looked at.
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign per_sel   = per_sel_q;
  assign per_we    = per_we_q;
  assign per_addr  = per_addr_q;
  assign per_wdata = per_wdata_q;

`ifdef MIO_BUS_ERRLOG_EN
  logic [31:0] err_addr_q;
  logic [7:0]  err_cnt_q;

  // Record the faulting address and bump a saturating count on every error response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else if (state_q == ST_RESP && err_q) begin
      err_addr_q <= addr_q;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;
`else
  logic unused_addr;
  assign unused_addr = ^addr_q;
  assign err_addr    = '0;
  assign err_cnt     = '0;
`endif

endmodule
